tdm_demux: RTL

TDM_DEMUX -- requirements
Module: tdm_demux

---
 rtl/tdm_demux.sv | 96 +++++++++
 1 files changed

// File: rtl/tdm_demux.sv
// Receive-side 1:2 TDM demultiplexer: hunts for fsync, then splits each
// 2*W-bit frame into a channel-1 word and a channel-2 word.
module tdm_demux #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         din,
  input  logic         fsync,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic         v1,
  output logic         v2,
  output logic         locked,
  output logic         sync_err
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    CH1  = 2'd1,
    CH2  = 2'd2
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  shift_reg;
  logic [W-1:0]  y1_reg;
  logic [W-1:0]  y2_reg;
  logic          v1_reg;
  logic          v2_reg;
  logic          err_reg;
  logic          boundary;

  // CH1 with a zero count only occurs right after a channel-2 word completes,
  // so it doubles as the frame-boundary check without a dedicated state.
  assign boundary = (state_reg == CH1) && (cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= HUNT;
      cnt_reg   <= '0;
      shift_reg <= '0;
      y1_reg    <= '0;
      y2_reg    <= '0;
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      v1_reg  <= 1'b0;
      v2_reg  <= 1'b0;
      err_reg <= 1'b0;
      if (en) begin
        if (fsync) begin
          // fsync always (re)starts channel 1; it is only legal in HUNT or at a boundary
          err_reg   <= (state_reg != HUNT) && !boundary;
          shift_reg <= W'(din);
          cnt_reg   <= CW'(1);
          state_reg <= CH1;
        end else if (state_reg == HUNT) begin
          state_reg <= HUNT;
        end else if (boundary) begin
          err_reg   <= 1'b1;
          state_reg <= HUNT;
        end else begin
          shift_reg <= {shift_reg[W-2:0], din};
          if (cnt_reg == LAST) begin
            cnt_reg <= '0;
            if (state_reg == CH1) begin
              y1_reg    <= {shift_reg[W-2:0], din};
              v1_reg    <= 1'b1;
              state_reg <= CH2;
            end else begin
              y2_reg    <= {shift_reg[W-2:0], din};
              v2_reg    <= 1'b1;
              state_reg <= CH1;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      end
    end
  end

  assign y1       = y1_reg;
  assign y2       = y2_reg;
  assign v1       = v1_reg;
  assign v2       = v2_reg;
  assign sync_err = err_reg;
  assign locked   = (state_reg != HUNT);

endmodule
